// File: rtl/fish_pkg.sv
// Shared types and constants for the fishing-hook arbiter slice.
package fish_pkg;

    typedef enum logic [1:0] {
        SLOT_SWIM   = 2'd0,
        SLOT_HOOKED = 2'd1,
        SLOT_WAIT   = 2'd2,
        SLOT_SPAWN  = 2'd3
    } slot_state_e;

    typedef enum logic {
        HOOK_FREE = 1'b0,
        HOOK_HELD = 1'b1
    } hook_state_e;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hB2;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [9:0] SCORE_MAX = 10'd999;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fish_hook_arbiter_if.sv
// Hook/slot bus between the fish movers, the mouse logic and the score display.
interface fish_hook_arbiter_if #(
    parameter int unsigned NUM_FISH = 4
);
    logic                    tick;
    logic                    pause;
    logic [NUM_FISH-1:0]     hit_req;
    logic [8:0]              hook_y;
    logic                    reel_btn;
    logic                    hook_busy;
    logic [2:0]              hook_owner;
    logic [2*NUM_FISH-1:0]   slot_state;
    logic [NUM_FISH-1:0]     spawn;
    logic                    spawn_dir;
    logic                    catch_pulse;
    logic [9:0]              score;

    modport master (
        output tick, pause, hit_req, hook_y, reel_btn,
        input  hook_busy, hook_owner, slot_state, spawn, spawn_dir, catch_pulse, score
    );

    modport slave (
        input  tick, pause, hit_req, hook_y, reel_btn,
        output hook_busy, hook_owner, slot_state, spawn, spawn_dir, catch_pulse, score
    );

endinterface

// File: rtl/fish_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at the slot after ptr.
module fish_rr_arbiter #(
    parameter int unsigned NUM_FISH = 4
) (
    input  logic [NUM_FISH-1:0] req,
    input  logic [2:0]          ptr,
    output logic [NUM_FISH-1:0] gnt,
    output logic [2:0]          gnt_idx,
    output logic                gnt_valid
);

    // Pick the requester with the smallest rotated distance from ptr+1
    always_comb begin
        int unsigned p;
        p         = 32'(ptr);
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_FISH; k++) begin
            for (int unsigned i = 0; i < NUM_FISH; i++) begin
                if (!gnt_valid && req[i] && (((i + NUM_FISH - p - 1) % NUM_FISH) == k)) begin
                    gnt[i]    = 1'b1;
                    gnt_idx   = 3'(i);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fish_hook_arbiter.sv
// Hook ownership, per-slot swim/hooked/wait/spawn lifecycle, score and
// respawn direction LFSR. Optional feature macro: HOOK_ESCAPE_EN (hooked
// fish escapes after ESCAPE_TICKS unpaused ticks without a catch).
module fish_hook_arbiter
    import fish_pkg::*;
#(
    parameter int unsigned NUM_FISH      = 4,
    parameter int unsigned SURFACE_Y     = 72,
    parameter int unsigned RESPAWN_TICKS = 60,
    parameter int unsigned ESCAPE_TICKS  = 255
) (
    input  logic              clk,
    input  logic              rst,
    fish_hook_arbiter_if.slave bus
);

    localparam int unsigned CNT_MAX = (RESPAWN_TICKS > ESCAPE_TICKS) ? RESPAWN_TICKS : ESCAPE_TICKS;
    localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RESPAWN_LOAD = CW'(RESPAWN_TICKS);

    hook_state_e         hook_q, hook_d;
    logic [2:0]          owner_q, owner_d;
    logic [2:0]          ptr_q, ptr_d;
    slot_state_e         slot_q [NUM_FISH];
    slot_state_e         slot_d [NUM_FISH];
    logic [CW-1:0]       wait_q [NUM_FISH];
    logic [CW-1:0]       wait_d [NUM_FISH];
    logic [7:0]          lfsr_q, lfsr_d;
    logic [9:0]          score_q, score_d;
    logic                catch_q, catch_d;

    logic [NUM_FISH-1:0] cand;
    logic [NUM_FISH-1:0] gnt;
    logic [2:0]          gnt_idx;
    logic                gnt_valid;
    logic                tick_en;
    logic                catch_now;
    logic                release_now;

    assign tick_en   = bus.tick & ~bus.pause;
    assign catch_now = (hook_q == HOOK_HELD) && bus.reel_btn && (bus.hook_y <= 9'(SURFACE_Y));

    // Only swimming fish may compete, and only while the hook is free
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NUM_FISH; i++) begin
            cand[i] = bus.hit_req[i] && (slot_q[i] == SLOT_SWIM) && (hook_q == HOOK_FREE);
        end
    end

    fish_rr_arbiter #(
        .NUM_FISH (NUM_FISH)
    ) u_rr (
        .req       (cand),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

`ifdef HOOK_ESCAPE_EN
    localparam logic [CW-1:0] ESCAPE_LOAD = CW'(ESCAPE_TICKS);

    logic [CW-1:0] esc_q, esc_d;
    logic          escape_now;

    // A catch in the expiry cycle takes priority over the escape
    assign escape_now  = (hook_q == HOOK_HELD) && (esc_q == '0) && !catch_now;
    assign release_now = catch_now | escape_now;

    // Escape countdown: loaded at grant, runs on unpaused ticks while held
    always_comb begin
        esc_d = esc_q;
        if (gnt_valid) begin
            esc_d = ESCAPE_LOAD;
        end else if ((hook_q == HOOK_HELD) && tick_en && (esc_q != '0)) begin
            esc_d = esc_q - CW'(1);
        end
    end

    // Escape counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            esc_q <= '0;
        end else begin
            esc_q <= esc_d;
        end
    end
`else
    assign release_now = catch_now;
`endif

    // Next-state for hook FSM, slot lifecycles, score and LFSR
    always_comb begin
        hook_d  = hook_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lfsr_d  = lfsr_q;
        score_d = score_q;
        catch_d = catch_now;

        case (hook_q)
            HOOK_FREE: begin
                if (gnt_valid) begin
                    hook_d  = HOOK_HELD;
                    owner_d = gnt_idx;
                    ptr_d   = gnt_idx;
                end
            end
            HOOK_HELD: begin
                if (release_now) begin
                    hook_d = HOOK_FREE;
                end
            end
            default: hook_d = HOOK_FREE;
        endcase

        if (catch_now && (score_q < SCORE_MAX)) begin
            score_d = score_q + 10'd1;
        end

        if (tick_en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end

        for (int unsigned i = 0; i < NUM_FISH; i++) begin
            slot_d[i] = slot_q[i];
            wait_d[i] = wait_q[i];
            case (slot_q[i])
                SLOT_SWIM: begin
                    if (gnt[i]) begin
                        slot_d[i] = SLOT_HOOKED;
                    end
                end
                SLOT_HOOKED: begin
                    if (release_now && (owner_q == 3'(i))) begin
                        slot_d[i] = SLOT_WAIT;
                        wait_d[i] = RESPAWN_LOAD;
                    end
                end
                SLOT_WAIT: begin
                    if (wait_q[i] == '0) begin
                        slot_d[i] = SLOT_SPAWN;
                    end else if (tick_en) begin
                        wait_d[i] = wait_q[i] - CW'(1);
                    end
                end
                SLOT_SPAWN: slot_d[i] = SLOT_SWIM;
                default:    slot_d[i] = SLOT_SWIM;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hook_q  <= HOOK_FREE;
            owner_q <= '0;
            ptr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            score_q <= '0;
            catch_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_FISH; i++) begin
                slot_q[i] <= SLOT_SWIM;
                wait_q[i] <= '0;
            end
        end else begin
            hook_q  <= hook_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lfsr_q  <= lfsr_d;
            score_q <= score_d;
            catch_q <= catch_d;
            for (int unsigned i = 0; i < NUM_FISH; i++) begin
                slot_q[i] <= slot_d[i];
                wait_q[i] <= wait_d[i];
            end
        end
    end

    // Pack slot states and decode spawn pulses from the SPAWN state
    always_comb begin
        bus.slot_state = '0;
        bus.spawn      = '0;
        for (int unsigned i = 0; i < NUM_FISH; i++) begin
            bus.slot_state[2*i +: 2] = slot_q[i];
            bus.spawn[i]             = (slot_q[i] == SLOT_SPAWN);
        end
    end

    assign bus.spawn_dir   = (|bus.spawn) & lfsr_q[0];
    assign bus.hook_busy   = (hook_q == HOOK_HELD);
    assign bus.hook_owner  = owner_q;
    assign bus.catch_pulse = catch_q;
    assign bus.score       = score_q;

endmodule

// File: tb/tb_fish_hook_arbiter.sv
// Directed bench for fish_hook_arbiter (NUM_FISH=4, RESPAWN_TICKS=3, ESCAPE_TICKS=5).
module tb_fish_hook_arbiter;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   model_score;
    logic found;

    fish_hook_arbiter_if #(.NUM_FISH(4)) bus ();

    fish_hook_arbiter #(
        .NUM_FISH      (4),
        .SURFACE_Y     (72),
        .RESPAWN_TICKS (3),
        .ESCAPE_TICKS  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b0;
        bus.tick     = 1'b0;
        bus.pause    = 1'b0;
        bus.hit_req  = '0;
        bus.hook_y   = 9'd100;
        bus.reel_btn = 1'b0;
        step();
        step();

        // Reset values
        check("rst_busy",   32'(bus.hook_busy),   0);
        check("rst_owner",  32'(bus.hook_owner),  0);
        check("rst_slots",  32'(bus.slot_state),  0);
        check("rst_spawn",  32'(bus.spawn),       0);
        check("rst_dir",    32'(bus.spawn_dir),   0);
        check("rst_catch",  32'(bus.catch_pulse), 0);
        check("rst_score",  32'(bus.score),       0);

        rst = 1'b1;
        step();

        // Four unpaused ticks: LFSR B2 -> 65 -> CB -> 96 -> 2C
        bus.tick = 1'b1;
        repeat (4) step();
        bus.tick = 1'b0;

        // First grant, pointer 0: search starts at slot 1
        bus.hit_req = 4'b0110;
        step();
        check("grant1_owner", 32'(bus.hook_owner), 1);
        check("grant1_busy",  32'(bus.hook_busy),  1);
        check("grant1_slots", 32'(bus.slot_state), 32'h04);
        step();
        check("held_ignore",  32'(bus.slot_state), 32'h04);
        bus.hit_req = '0;

        // Reel below surface line: no catch
        bus.hook_y   = 9'd80;
        bus.reel_btn = 1'b1;
        step();
        check("deep_catch", 32'(bus.catch_pulse), 0);
        check("deep_score", 32'(bus.score),       0);
        check("deep_busy",  32'(bus.hook_busy),   1);

        // Exactly at surface: catch
        bus.hook_y = 9'd72;
        step();
        check("catch1_pulse", 32'(bus.catch_pulse), 1);
        check("catch1_score", 32'(bus.score),       1);
        check("catch1_slots", 32'(bus.slot_state),  32'h08);
        check("catch1_busy",  32'(bus.hook_busy),   0);
        bus.reel_btn = 1'b0;
        bus.hook_y   = 9'd100;
        step();
        check("catch1_once",  32'(bus.catch_pulse), 0);
        check("catch1_hold",  32'(bus.score),       1);

        // Paused ticks must not count down
        bus.pause = 1'b1;
        bus.tick  = 1'b1;
        repeat (3) step();
        check("pause_wait", 32'(bus.slot_state), 32'h08);
        check("pause_nospawn", 32'(bus.spawn), 0);

        // Three unpaused ticks: 3 -> 0, spawn on the following edge
        bus.pause = 1'b0;
        repeat (3) step();
        check("wait_zero_slots", 32'(bus.slot_state), 32'h08);
        check("wait_zero_spawn", 32'(bus.spawn),      0);
        bus.tick = 1'b0;
        step();
        // LFSR advanced 7 times: 2C -> 58 -> B0 -> 61, bit0 = 1
        check("spawn_slots", 32'(bus.slot_state), 32'h0C);
        check("spawn_pulse", 32'(bus.spawn),      32'h2);
        check("spawn_dir",   32'(bus.spawn_dir),  1);
        step();
        check("respawn_slots", 32'(bus.slot_state), 0);
        check("respawn_pulse", 32'(bus.spawn),      0);
        check("respawn_dir",   32'(bus.spawn_dir),  0);

        // Round robin: last grant 1, so slot 2 wins over slot 1
        bus.hit_req = 4'b0110;
        step();
        check("rr_owner", 32'(bus.hook_owner), 2);
        check("rr_slots", 32'(bus.slot_state), 32'h10);

        // Catch while slot 1 requests: hook free first, grant one cycle later
        bus.hit_req  = 4'b0010;
        bus.reel_btn = 1'b1;
        bus.hook_y   = 9'd72;
        step();
        check("catch2_pulse", 32'(bus.catch_pulse), 1);
        check("catch2_busy",  32'(bus.hook_busy),   0);
        check("catch2_score", 32'(bus.score),       2);
        check("catch2_slots", 32'(bus.slot_state),  32'h20);
        step();
        check("regrant_busy",  32'(bus.hook_busy),   1);
        check("regrant_owner", 32'(bus.hook_owner),  1);
        check("regrant_catch", 32'(bus.catch_pulse), 0);
        check("regrant_slots", 32'(bus.slot_state),  32'h24);

        // Drive catches continuously until the score saturates
        model_score  = 2;
        bus.hit_req  = 4'b1111;
        bus.tick     = 1'b1;
        bus.hook_y   = 9'd0;
        for (int n = 0; n < 8000 && model_score != 999; n++) begin
            step();
            if (bus.catch_pulse) model_score = (model_score < 999) ? model_score + 1 : 999;
        end
        check("sat_reached", 32'(model_score), 999);
        check("sat_score",   32'(bus.score),   999);

        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (bus.catch_pulse) found = 1'b1;
        end
        check("sat_pulse", 32'(found),     1);
        check("sat_hold",  32'(bus.score), 999);

        // Async reset while the hook is held
        bus.reel_btn = 1'b0;
        found = bus.hook_busy;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            found = bus.hook_busy;
        end
        check("prereset_busy", 32'(found), 1);
        bus.hit_req  = '0;
        bus.reel_btn = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.hook_busy),   0);
        check("mid_rst_owner", 32'(bus.hook_owner),  0);
        check("mid_rst_slots", 32'(bus.slot_state),  0);
        check("mid_rst_score", 32'(bus.score),       0);
        check("mid_rst_catch", 32'(bus.catch_pulse), 0);
        check("mid_rst_spawn", 32'(bus.spawn),       0);
        step();
        check("mid_rst_nocatch", 32'(bus.score), 0);
        bus.reel_btn = 1'b0;
        bus.tick     = 1'b0;
        bus.hook_y   = 9'd100;
        rst = 1'b1;
        step();

        // Hold slot 0 without reeling for five ticks
        bus.hit_req = 4'b0001;
        step();
        check("esc_owner", 32'(bus.hook_owner), 0);
        check("esc_slots", 32'(bus.slot_state), 32'h01);
        bus.hit_req = '0;
        bus.tick    = 1'b1;
        repeat (5) step();
        check("esc_pre_busy", 32'(bus.hook_busy), 1);
        bus.tick = 1'b0;
        step();
`ifdef HOOK_ESCAPE_EN
        check("esc_busy",  32'(bus.hook_busy),   0);
        check("esc_slots_wait", 32'(bus.slot_state), 32'h02);
`else
        check("noesc_busy",  32'(bus.hook_busy),  1);
        check("noesc_slots", 32'(bus.slot_state), 32'h01);
`endif
        check("esc_score", 32'(bus.score),       0);
        check("esc_catch", 32'(bus.catch_pulse), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
